// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - byte-stream loader that fills imem/dmem and then releases the mips core
// Optional per-frame checksum byte: BOOT_CHECKSUM_EN
module mips_boot_loader #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_WORDS = 16,
  parameter int DMEM_WORDS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_CNT, S_GET_DATA, S_WRITE, S_RUN, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_CNT, S_GET_DATA, S_WRITE, S_RUN
  } state_t;
`endif

  localparam logic [7:0] CMD_HALT    = 8'h00;
  localparam logic [7:0] CMD_LOAD_I  = 8'h01;
  localparam logic [7:0] CMD_LOAD_D  = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_CLR_ERR = 8'h04;

  state_t     state;
  logic       sel_d;
  logic [8:0] remaining;
  logic [1:0] byte_idx;
  logic       fire;
  logic       oob;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign fire = in_valid && in_ready;
  assign oob  = sel_d ? (32'(mem_addr) >= DMEM_WORDS) : (32'(mem_addr) >= IMEM_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      sel_d     <= 1'b0;
      remaining <= '0;
      byte_idx  <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        S_IDLE: if (fire) begin
          case (in_data)
            CMD_LOAD_I: begin sel_d <= 1'b0; busy <= 1'b1; state <= S_GET_ADDR; end
            CMD_LOAD_D: begin sel_d <= 1'b1; busy <= 1'b1; state <= S_GET_ADDR; end
            CMD_RUN: begin
`ifdef BOOT_CHECKSUM_EN
              // A failed load must not start the core.
              if (!err) begin
                cpu_rst <= 1'b1;
                state   <= S_RUN;
              end
`else
              cpu_rst <= 1'b1;
              state   <= S_RUN;
`endif
            end
            CMD_CLR_ERR: err <= 1'b0;
            default:     err <= 1'b1;
          endcase
        end
        S_GET_ADDR: if (fire) begin
          mem_addr <= ADDR_W'(in_data);
          state    <= S_GET_CNT;
        end
        S_GET_CNT: if (fire) begin
          remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          byte_idx  <= '0;
`ifdef BOOT_CHECKSUM_EN
          csum      <= '0;
`endif
          state     <= S_GET_DATA;
        end
        S_GET_DATA: if (fire) begin
          // Shifting left leaves the first byte of the word in [31:24].
          mem_wdata <= {mem_wdata[23:0], in_data};
          byte_idx  <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum      <= csum ^ in_data;
`endif
          if (byte_idx == 2'd3) begin
            in_ready <= 1'b0;
            state    <= S_WRITE;
            if (oob)        err     <= 1'b1;
            else if (sel_d) dmem_we <= 1'b1;
            else            imem_we <= 1'b1;
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + ADDR_W'(1);
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) begin
`ifdef BOOT_CHECKSUM_EN
            state <= S_CHK;
`else
            busy  <= 1'b0;
            state <= S_IDLE;
`endif
          end else begin
            state <= S_GET_DATA;
          end
        end
        S_RUN: if (fire && in_data == CMD_HALT) begin
          cpu_rst <= 1'b0;
          state   <= S_IDLE;
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHK: if (fire) begin
          if (in_data != csum) err <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
